mem_port_arbiter: RTL and testbench

- Controller that shares the single-port 1024x32 data RAM between two requesters: port 0 is the CPU MEM stage, port 1 is the loader/debug port.
- Sequences every access: word read, word write, byte read (zero-extended), and byte write.
- A byte write is done as a read-modify-write, so the RAM only ever performs full-word writes.
- Sits between the MEM stage and the RAM array. It owns all RAM enable, write-enable, address and data lines.

---
 rtl/mem_arb_pkg.sv | 29 ++
 rtl/mem_arb_byte_lane.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 177 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port data-RAM arbiter.
// Round-robin arbitration is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

  localparam int RAM_AW = 10;
  localparam int LANE_W = 2;

  localparam logic [LANE_W-1:0] LANE0 = 2'd0;
  localparam logic [LANE_W-1:0] LANE1 = 2'd1;
  localparam logic [LANE_W-1:0] LANE2 = 2'd2;
  localparam logic [LANE_W-1:0] LANE3 = 2'd3;

  // Access class encoded as {we, byte}.
  localparam logic [1:0] OP_LW = 2'b00;
  localparam logic [1:0] OP_LB = 2'b01;
  localparam logic [1:0] OP_SW = 2'b10;
  localparam logic [1:0] OP_SB = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    RD_WAIT,
    RMW_RD,
    RMW_MRG,
    RMW_WR
  } arb_state_e;

endpackage

// File: rtl/mem_arb_byte_lane.sv
// Byte-lane helper: zero-extended lane extract and single-lane merge
// on a little-endian 32-bit word.
module mem_arb_byte_lane
  import mem_arb_pkg::*;
(
  input  logic [31:0]       word,
  input  logic [LANE_W-1:0] lane,
  input  logic [7:0]        byte_in,
  output logic [31:0]       extract,
  output logic [31:0]       merged
);

  always_comb begin
    extract = '0;
    merged  = word;
    case (lane)
      LANE0: begin
        extract[7:0] = word[7:0];
        merged[7:0]  = byte_in;
      end
      LANE1: begin
        extract[7:0]  = word[15:8];
        merged[15:8]  = byte_in;
      end
      LANE2: begin
        extract[7:0]  = word[23:16];
        merged[23:16] = byte_in;
      end
      LANE3: begin
        extract[7:0]  = word[31:24];
        merged[31:24] = byte_in;
      end
      default: begin
        extract = '0;
        merged  = word;
      end
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares a single-port 1024x32 RAM between the CPU MEM stage (port 0) and the
// loader/debug port (port 1). Define MEM_ARB_ROUND_ROBIN_EN for round-robin.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RAM_AW = mem_arb_pkg::RAM_AW,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic              r0_byte,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_ack,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic              r1_byte,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_ack,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  import mem_arb_pkg::*;

  // Handshake: a requester raises req with its command fields and holds it;
  // the controller samples req only in IDLE, latches the command, and answers
  // with a one-cycle ack (read data valid in that same cycle only).

  arb_state_e        state;
  logic              gnt;
  logic              cap_byte;
  logic [LANE_W-1:0] cap_lane;
  logic [7:0]        cap_bdata;

  logic              any_req;
  logic              pick1;
  logic              w_we;
  logic              w_byte;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [RAM_AW-1:0] w_idx;
  logic [LANE_W-1:0] w_lane;
  logic              addr_hi_unused;

  logic [31:0]       lane_extract;
  logic [31:0]       lane_merged;
  logic [DATA_W-1:0] rd_word;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic ptr;  // 1 = port 1 favoured on a tie
  always_comb pick1 = r1_req && (!r0_req || ptr);
`else
  always_comb pick1 = r1_req && !r0_req;
`endif

  always_comb begin
    any_req = r0_req | r1_req;
    w_we    = pick1 ? r1_we    : r0_we;
    w_byte  = pick1 ? r1_byte  : r0_byte;
    w_addr  = pick1 ? r1_addr  : r0_addr;
    w_wdata = pick1 ? r1_wdata : r0_wdata;
    w_idx   = w_addr[RAM_AW+1:2];
    w_lane  = w_addr[LANE_W-1:0];
  end

  // Address bits above the word index do not select RAM storage.
  assign addr_hi_unused = ^w_addr[ADDR_W-1:RAM_AW+2];

  mem_arb_byte_lane u_byte_lane (
    .word    (ram_rdata),
    .lane    (cap_lane),
    .byte_in (cap_bdata),
    .extract (lane_extract),
    .merged  (lane_merged)
  );

  // Read data is only presented to the granted port during RD_WAIT.
  always_comb begin
    rd_word  = cap_byte ? lane_extract : ram_rdata;
    r0_rdata = (state == RD_WAIT && !gnt) ? rd_word : '0;
    r1_rdata = (state == RD_WAIT &&  gnt) ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      cap_byte  <= 1'b0;
      cap_lane  <= '0;
      cap_bdata <= '0;
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      busy      <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      ptr       <= 1'b0;
`endif
    end else begin
      r0_ack <= 1'b0;
      r1_ack <= 1'b0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            gnt       <= pick1;
            cap_byte  <= w_byte;
            cap_lane  <= w_lane;
            cap_bdata <= w_wdata[7:0];
            ram_addr  <= w_idx;
            ram_en    <= 1'b1;
            busy      <= 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
            ptr       <= !pick1;
`endif
            case ({w_we, w_byte})
              OP_SW: begin
                state     <= WR;
                ram_we    <= 1'b1;
                ram_wdata <= w_wdata;
                r0_ack    <= !pick1;
                r1_ack    <= pick1;
              end
              OP_SB:        state <= RMW_RD;
              OP_LW, OP_LB: state <= RD;
              default:      state <= RD;
            endcase
          end
        end
        WR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        RD: begin
          state  <= RD_WAIT;
          r0_ack <= !gnt;
          r1_ack <= gnt;
        end
        RD_WAIT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        RMW_RD: state <= RMW_MRG;
        RMW_MRG: begin
          // The RAM word is only touched here, so an aborted RMW leaves it intact.
          state     <= RMW_WR;
          ram_en    <= 1'b1;
          ram_we    <= 1'b1;
          ram_wdata <= lane_merged;
          r0_ack    <= !gnt;
          r1_ack    <= gnt;
        end
        RMW_WR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random
// accesses checked against a word-array reference memory.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        r0_req, r0_we, r0_byte;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r0_ack;
  logic        r1_req, r1_we, r1_byte;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic        r1_ack;
  logic        ram_en, ram_we, busy;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_clr;

  logic [31:0] ram     [0:1023];
  logic [31:0] ref_mem [0:1023];

  int total = 0;
  int bad = 0;
  int last_grant = 1;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_we(r0_we), .r0_byte(r0_byte), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_byte(r1_byte), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
  );

  // Synchronous single-port RAM: read data appears the cycle after enable.
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 1024; i++) ram[i] <= '0;
      ram_rdata <= '0;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata <= ram[ram_addr];
    end
  end

  function automatic int ref_idx(input logic [31:0] addr);
    return int'((addr / 4) % 1024);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] addr, input logic byt);
    logic [31:0] w;
    int sh;
    w  = ref_mem[ref_idx(addr)];
    sh = 8 * int'(addr % 4);
    return byt ? ((w >> sh) & 32'hFF) : w;
  endfunction

  function automatic void ref_write(input logic [31:0] addr, input logic byt, input logic [31:0] d);
    logic [31:0] w;
    int sh;
    w  = ref_mem[ref_idx(addr)];
    sh = 8 * int'(addr % 4);
    if (byt) w = (w & ~(32'hFF << sh)) | ((d & 32'hFF) << sh);
    else     w = d;
    ref_mem[ref_idx(addr)] = w;
  endfunction

  function automatic int exp_lat(input logic we, input logic byt);
    if (!we) return 2;
    return byt ? 3 : 1;
  endfunction

  function automatic int exp_winner(input logic q0, input logic q1);
    if (q0 && q1) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      return 1 - last_grant;
`else
      return 0;
`endif
    end
    return q1 ? 1 : 0;
  endfunction

  task automatic clear_inputs();
    r0_req = 0; r0_we = 0; r0_byte = 0; r0_addr = '0; r0_wdata = '0;
    r1_req = 0; r1_we = 0; r1_byte = 0; r1_addr = '0; r1_wdata = '0;
  endtask

  // Single-port access driver; returns at a negedge with the DUT back in IDLE.
  task automatic do_access(input int port, input logic we, input logic byt,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output logic [31:0] rdata,
                           output logic [9:0] wr_idx, output logic stray);
    lat = 0; rdata = '0; wr_idx = '0; stray = 1'b0;
    if (port == 0) begin
      r0_req = 1; r0_we = we; r0_byte = byt; r0_addr = addr; r0_wdata = wdata;
    end else begin
      r1_req = 1; r1_we = we; r1_byte = byt; r1_addr = addr; r1_wdata = wdata;
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if ((port == 0) ? r1_ack : r0_ack) stray = 1'b1;
      if ((port == 0) ? r0_ack : r1_ack) begin
        lat   = i;
        rdata = (port == 0) ? r0_rdata : r1_rdata;
        if (ram_en && ram_we) wr_idx = ram_addr;
        break;
      end
    end
    r0_req = 0; r1_req = 0;
    last_grant = port;
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL access_timeout port=%0d addr=%h got no ack in 20 cycles", port, addr);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1; ram_clr = 1;
    clear_inputs();
    repeat (3) @(negedge clk);
    reset = 0; ram_clr = 0;
    last_grant = 1;
    @(negedge clk);
    total++;
    if ({r0_ack, r1_ack, busy, ram_en, ram_we} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b exp=00000", {r0_ack, r1_ack, busy, ram_en, ram_we});
    end
    total++;
    if (ram_addr !== 10'd0 || ram_wdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_ram_bus got addr=%h wdata=%h exp 0", ram_addr, ram_wdata);
    end
    total++;
    if (r0_rdata !== 32'd0 || r1_rdata !== 32'd0) begin
      bad++;
      $display("FAIL reset_rdata got=%h/%h exp 0", r0_rdata, r1_rdata);
    end
  endtask

  task automatic test_word();
    int lat; logic [31:0] rd; logic [9:0] wi; logic st;
    do_access(0, 1, 0, 32'h10, 32'hDEADBEEF, lat, rd, wi, st);
    ref_write(32'h10, 0, 32'hDEADBEEF);
    total++;
    if (lat !== 1 || wi !== 10'd4 || st) begin
      bad++;
      $display("FAIL word_write got lat=%0d idx=%0d stray=%b exp lat=1 idx=4 stray=0", lat, wi, st);
    end
    do_access(0, 0, 0, 32'h10, 32'h0, lat, rd, wi, st);
    total++;
    if (lat !== 2 || rd !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL word_read got lat=%0d data=%h exp lat=2 data=deadbeef", lat, rd);
    end
  endtask

  task automatic test_byte();
    int lat; logic [31:0] rd; logic [9:0] wi; logic st;
    do_access(1, 1, 0, 32'h10, 32'h11223344, lat, rd, wi, st);
    ref_write(32'h10, 0, 32'h11223344);
    do_access(0, 1, 1, 32'h12, 32'hFFFFFF5A, lat, rd, wi, st);
    ref_write(32'h12, 1, 32'hFFFFFF5A);
    total++;
    if (lat !== 3 || wi !== 10'd4 || st) begin
      bad++;
      $display("FAIL byte_write got lat=%0d idx=%0d stray=%b exp lat=3 idx=4 stray=0", lat, wi, st);
    end
    do_access(0, 0, 0, 32'h10, 32'h0, lat, rd, wi, st);
    total++;
    if (rd !== 32'h115A3344) begin
      bad++;
      $display("FAIL byte_merge got=%h exp=115a3344", rd);
    end
    do_access(1, 0, 1, 32'h13, 32'h0, lat, rd, wi, st);
    total++;
    if (lat !== 2 || rd !== 32'h00000011) begin
      bad++;
      $display("FAIL byte_read got lat=%0d data=%h exp lat=2 data=00000011", lat, rd);
    end
  endtask

  task automatic test_addr_wrap();
    int lat; logic [31:0] rd; logic [9:0] wi; logic st;
    do_access(0, 1, 0, 32'hFFFFF004, 32'hA5A55A5A, lat, rd, wi, st);
    ref_write(32'hFFFFF004, 0, 32'hA5A55A5A);
    total++;
    if (wi !== 10'd1) begin
      bad++;
      $display("FAIL addr_wrap got idx=%0d exp idx=1", wi);
    end
    do_access(1, 0, 0, 32'h00000004, 32'h0, lat, rd, wi, st);
    total++;
    if (rd !== 32'hA5A55A5A) begin
      bad++;
      $display("FAIL addr_alias got=%h exp=a5a55a5a", rd);
    end
  endtask

  task automatic test_req_drop();
    int lat; logic [31:0] rd; logic [9:0] wi; logic st;
    int seen;
    seen = 0;
    r1_req = 1; r1_we = 1; r1_byte = 1; r1_addr = 32'h21; r1_wdata = 32'h000000C3;
    @(negedge clk);
    r1_req = 0;
    if (r1_ack) seen = 1;
    for (int i = 2; i <= 10 && seen == 0; i++) begin
      @(negedge clk);
      if (r1_ack) seen = i;
    end
    last_grant = 1;
    ref_write(32'h21, 1, 32'hC3);
    @(negedge clk);
    total++;
    if (seen !== 3) begin
      bad++;
      $display("FAIL req_drop_ack got cycle=%0d exp cycle=3", seen);
    end
    do_access(0, 0, 0, 32'h20, 32'h0, lat, rd, wi, st);
    total++;
    if (rd !== ref_read(32'h20, 0)) begin
      bad++;
      $display("FAIL req_drop_data got=%h exp=%h", rd, ref_read(32'h20, 0));
    end
  endtask

  task automatic test_back_to_back();
    int n, prev_cyc, gap_bad;
    logic [31:0] a0, a1, exp_d, got_d;
    int p, ep;
    a0 = 32'h10; a1 = 32'h04;
    n = 0; prev_cyc = 0; gap_bad = 0;
    r0_req = 1; r0_we = 0; r0_byte = 0; r0_addr = a0;
    r1_req = 1; r1_we = 0; r1_byte = 0; r1_addr = a1;
    for (int c = 1; c <= 60 && n < 8; c++) begin
      @(negedge clk);
      if (r0_ack || r1_ack) begin
        p  = r1_ack ? 1 : 0;
        ep = exp_winner(1, 1);
        got_d = p ? r1_rdata : r0_rdata;
        exp_d = ref_read(ep ? a1 : a0, 0);
        total++;
        if ((r0_ack && r1_ack) || p != ep || got_d !== exp_d) begin
          bad++;
          $display("FAIL arb_grant n=%0d got port=%0d data=%h exp port=%0d data=%h",
                   n, p, got_d, ep, exp_d);
        end
        if (n > 0 && c - prev_cyc != 3) gap_bad++;
        last_grant = ep;
        prev_cyc = c;
        n++;
      end
    end
    r0_req = 0; r1_req = 0;
    @(negedge clk);
    total++;
    if (n != 8 || gap_bad != 0) begin
      bad++;
      $display("FAIL arb_throughput got grants=%0d bad_gaps=%0d exp grants=8 bad_gaps=0", n, gap_bad);
    end
  endtask

  task automatic test_reset_mid_rmw();
    int lat; logic [31:0] rd; logic [9:0] wi; logic st;
    logic ack_early;
    do_access(0, 1, 0, 32'h40, 32'hCAFEF00D, lat, rd, wi, st);
    ref_write(32'h40, 0, 32'hCAFEF00D);
    r0_req = 1; r0_we = 1; r0_byte = 1; r0_addr = 32'h41; r0_wdata = 32'h77;
    @(negedge clk);
    ack_early = r0_ack | r1_ack;
    @(negedge clk);
    ack_early = ack_early | r0_ack | r1_ack;
    reset = 1; r0_req = 0;
    @(negedge clk);
    total++;
    if (ack_early || r0_ack || r1_ack || busy || ram_en) begin
      bad++;
      $display("FAIL reset_abort got ack=%b busy=%b ram_en=%b exp all 0",
               ack_early | r0_ack | r1_ack, busy, ram_en);
    end
    reset = 0;
    last_grant = 1;
    @(negedge clk);
    do_access(1, 0, 0, 32'h40, 32'h0, lat, rd, wi, st);
    total++;
    if (rd !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL reset_word_kept got=%h exp=cafef00d", rd);
    end
  endtask

  task automatic test_random();
    int lat, port; logic [31:0] rd, addr, wd, exp_d; logic [9:0] wi; logic st, we, byt;
    int errs, n_reads;
    errs = 0; n_reads = 0;
    for (int k = 0; k < 150; k++) begin
      port = int'($urandom_range(0, 1));
      we   = 1'($urandom_range(0, 1));
      byt  = 1'($urandom_range(0, 1));
      addr = ($urandom & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      wd   = $urandom;
      exp_d = ref_read(addr, byt);
      do_access(port, we, byt, addr, wd, lat, rd, wi, st);
      if (we) ref_write(addr, byt, wd);
      total++;
      if (lat != exp_lat(we, byt) || st || (!we && rd !== exp_d) ||
          (we && wi !== 10'(ref_idx(addr)))) begin
        bad++; errs++;
        if (errs <= 5)
          $display("FAIL random k=%0d port=%0d we=%b byte=%b addr=%h got lat=%0d data=%h idx=%0d exp lat=%0d data=%h idx=%0d",
                   k, port, we, byt, addr, lat, rd, wi, exp_lat(we, byt), exp_d, ref_idx(addr));
      end
      if (!we) n_reads++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    reset = 1; ram_clr = 1;
    clear_inputs();
    test_reset();
    test_word();
    test_byte();
    test_addr_wrap();
    test_req_drop();
    test_back_to_back();
    test_reset_mid_rmw();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
